// File: rtl/dot_feeder.sv
// Dot-product sequencer: streams two operand vectors from memory into an external
// MAC element, then captures the accumulator and presents it on a ready/valid port.
module dot_feeder #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [ADDR_W-1:0] LEN,
    input  logic [ADDR_W-1:0] BASE_A,
    input  logic [ADDR_W-1:0] BASE_B,
    output logic              MEM_RD_EN,
    output logic [ADDR_W-1:0] MEM_A_ADDR,
    output logic [ADDR_W-1:0] MEM_B_ADDR,
    input  logic [DATA_W-1:0] MEM_A_DATA,
    input  logic [DATA_W-1:0] MEM_B_DATA,
    output logic [DATA_W-1:0] PE_A,
    output logic [DATA_W-1:0] PE_B,
    output logic              PE_MAC,
    output logic              PE_CLR,
    input  logic [DATA_W-1:0] PE_ACC,
    output logic [DATA_W-1:0] RES_DATA,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        READ   = 3'd2,
        DRAIN  = 3'd3,
        SETTLE = 3'd4,
        HOLD   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

    state_t              state_r;
    state_t              next_state_s;
    logic [ADDR_W-1:0]   len_r;
    logic [ADDR_W-1:0]   base_a_r;
    logic [ADDR_W-1:0]   base_b_r;
    logic [ADDR_W-1:0]   cnt_r;
    logic [ADDR_W-1:0]   cnt_s;
    logic                mem_rd_en_r;
    logic                rd_en_s;
    logic [ADDR_W-1:0]   mem_a_addr_r;
    logic [ADDR_W-1:0]   mem_b_addr_r;
    logic [ADDR_W-1:0]   a_addr_s;
    logic [ADDR_W-1:0]   b_addr_s;
    logic                pe_mac_r;
    logic                pe_clr_r;
    logic                clr_s;
    logic                busy_r;
    logic                busy_s;
    logic                res_valid_r;
    logic                res_valid_s;
    logic [DATA_W-1:0]   res_data_r;

    // FSM state register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; the element counter indexes the current READ cycle
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (START) next_state_s = CLEAR; else next_state_s = IDLE;
            CLEAR:   if (len_r != ZERO_A) next_state_s = READ; else next_state_s = SETTLE;
            READ:    if (cnt_r == (len_r - ONE_A)) next_state_s = DRAIN; else next_state_s = READ;
            DRAIN:   next_state_s = SETTLE;
            SETTLE:  next_state_s = HOLD;
            HOLD:    if (RES_READY) next_state_s = IDLE; else next_state_s = HOLD;
            default: next_state_s = IDLE;
        endcase
    end

    // FSM output logic: values the output registers take at the coming edge
    always_comb begin
        cnt_s       = ZERO_A;
        rd_en_s     = 1'b0;
        a_addr_s    = ZERO_A;
        b_addr_s    = ZERO_A;
        clr_s       = 1'b0;
        busy_s      = (next_state_s != IDLE);
        res_valid_s = (next_state_s == HOLD);
        if (next_state_s == READ) begin
            if (state_r == READ) begin
                cnt_s = cnt_r + ONE_A;
            end else begin
                cnt_s = ZERO_A;
            end
            rd_en_s  = 1'b1;
            a_addr_s = base_a_r + cnt_s;
            b_addr_s = base_b_r + cnt_s;
        end else begin
            rd_en_s = 1'b0;
        end
        if (next_state_s == CLEAR) begin
            clr_s = 1'b1;
        end else begin
            clr_s = 1'b0;
        end
    end

    // Command latch: LEN and bases are frozen at acceptance
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_r    <= ZERO_A;
            base_a_r <= ZERO_A;
            base_b_r <= ZERO_A;
        end else if ((state_r == IDLE) && START) begin
            len_r    <= LEN;
            base_a_r <= BASE_A;
            base_b_r <= BASE_B;
        end
    end

    // Output and counter registers; MAC enable trails the read strobe by one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_r        <= ZERO_A;
            mem_rd_en_r  <= 1'b0;
            mem_a_addr_r <= ZERO_A;
            mem_b_addr_r <= ZERO_A;
            pe_mac_r     <= 1'b0;
            pe_clr_r     <= 1'b0;
            busy_r       <= 1'b0;
            res_valid_r  <= 1'b0;
            res_data_r   <= ZERO_D;
        end else begin
            cnt_r        <= cnt_s;
            mem_rd_en_r  <= rd_en_s;
            mem_a_addr_r <= a_addr_s;
            mem_b_addr_r <= b_addr_s;
            pe_mac_r     <= mem_rd_en_r;
            pe_clr_r     <= clr_s;
            busy_r       <= busy_s;
            res_valid_r  <= res_valid_s;
            if (state_r == SETTLE) begin
                res_data_r <= PE_ACC;
            end
        end
    end

    assign MEM_RD_EN  = mem_rd_en_r;
    assign MEM_A_ADDR = mem_a_addr_r;
    assign MEM_B_ADDR = mem_b_addr_r;
    assign PE_MAC     = pe_mac_r;
    assign PE_CLR     = pe_clr_r;
    assign PE_A       = pe_mac_r ? MEM_A_DATA : ZERO_D;
    assign PE_B       = pe_mac_r ? MEM_B_DATA : ZERO_D;
    assign RES_DATA   = res_data_r;
    assign RES_VALID  = res_valid_r;
    assign BUSY       = busy_r;

endmodule

// File: tb/tb_dot_feeder.sv
// Self-checking bench for dot_feeder: behavioural memory and MAC models, with
// expected dot products computed directly as sums of products.
module tb_dot_feeder;
    localparam int AW = 8;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic [AW-1:0] LEN, BASE_A, BASE_B;
    logic          MEM_RD_EN;
    logic [AW-1:0] MEM_A_ADDR, MEM_B_ADDR;
    logic [DW-1:0] MEM_A_DATA, MEM_B_DATA;
    logic [DW-1:0] PE_A, PE_B, PE_ACC, RES_DATA;
    logic          PE_MAC, PE_CLR, RES_VALID, RES_READY, BUSY;

    always #5 CLK = ~CLK;

    dot_feeder #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .LEN(LEN), .BASE_A(BASE_A), .BASE_B(BASE_B),
        .MEM_RD_EN(MEM_RD_EN), .MEM_A_ADDR(MEM_A_ADDR), .MEM_B_ADDR(MEM_B_ADDR),
        .MEM_A_DATA(MEM_A_DATA), .MEM_B_DATA(MEM_B_DATA), .PE_A(PE_A), .PE_B(PE_B),
        .PE_MAC(PE_MAC), .PE_CLR(PE_CLR), .PE_ACC(PE_ACC), .RES_DATA(RES_DATA),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .BUSY(BUSY)
    );

    logic [DW-1:0] mem_a [0:255];
    logic [DW-1:0] mem_b [0:255];
    logic [DW-1:0] acc_m;

    // Synchronous-read memories: garbage when not strobed so unmasked operands show up
    always @(posedge CLK) begin
        if (MEM_RD_EN) begin
            MEM_A_DATA <= mem_a[MEM_A_ADDR];
            MEM_B_DATA <= mem_b[MEM_B_ADDR];
        end else begin
            MEM_A_DATA <= $urandom;
            MEM_B_DATA <= $urandom;
        end
    end

    // MAC element model (not reset, so stale sums survive a feeder reset)
    always @(posedge CLK) begin
        if (PE_CLR) acc_m <= '0;
        else if (PE_MAC) acc_m <= acc_m + PE_A * PE_B;
    end
    assign PE_ACC = acc_m;

    int n_tests = 0;
    int n_fail  = 0;

    int            obs_lat, obs_width, obs_rd, obs_clr, obs_overlap, obs_badzero;
    logic          obs_busy_after;
    logic [DW-1:0] obs_data;
    logic [AW-1:0] obs_a [0:255];
    logic [AW-1:0] obs_b [0:255];

    function automatic logic [DW-1:0] ref_dot(input int len, input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        logic [DW-1:0] s = '0;
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] ia = ba + AW'(i);
            logic [AW-1:0] ib = bb + AW'(i);
            s = s + mem_a[ia] * mem_b[ib];
        end
        return s;
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = $urandom;
            mem_b[i] = $urandom;
        end
    endtask

    // Issue one command and record what the DUT does until the result handshake ends
    task automatic run_dot(input int len, input logic [AW-1:0] ba, input logic [AW-1:0] bb);
        int n = 0;
        bit seen = 0;
        bit done = 0;
        @(negedge CLK);
        START = 1'b1; LEN = AW'(len); BASE_A = ba; BASE_B = bb;
        obs_lat = -1; obs_width = 0; obs_rd = 0; obs_clr = 0; obs_overlap = 0; obs_badzero = 0;
        obs_busy_after = 1'b1; obs_data = '0;
        @(posedge CLK);
        while (!done && n < len + 40) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                START = 1'b0; LEN = AW'($urandom); BASE_A = AW'($urandom); BASE_B = AW'($urandom);
            end
            if (MEM_RD_EN) begin
                if (obs_rd < 256) begin
                    obs_a[obs_rd] = MEM_A_ADDR;
                    obs_b[obs_rd] = MEM_B_ADDR;
                end
                obs_rd++;
            end
            if (PE_CLR) obs_clr++;
            if (PE_CLR && PE_MAC) obs_overlap++;
            if (!PE_MAC && (PE_A != '0 || PE_B != '0)) obs_badzero++;
            if (RES_VALID) begin
                if (!seen) begin seen = 1; obs_lat = n; obs_data = RES_DATA; end
                obs_width++;
            end else if (seen) begin
                done = 1;
                obs_busy_after = BUSY;
            end
        end
    endtask

    task automatic test_reset();
        logic [DW+2*AW+4:0] outs;
        RST = 1'b1; START = 1'b0; LEN = '0; BASE_A = '0; BASE_B = '0; RES_READY = 1'b1;
        #12;
        outs = {BUSY, MEM_RD_EN, PE_MAC, PE_CLR, RES_VALID, MEM_A_ADDR, MEM_B_ADDR, RES_DATA};
        n_tests++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_basic();
        randomize_mem();
        for (int i = 0; i < 4; i++) begin
            mem_a[i]      = DW'(i + 1);
            mem_b[16 + i] = DW'(i + 5);
        end
        RES_READY = 1'b1;
        run_dot(4, 8'd0, 8'd16);
        n_tests++; if (obs_lat !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d expected 8", obs_lat); end
        n_tests++; if (obs_data !== 32'd70) begin n_fail++; $display("FAIL basic_data: got %0d expected 70", obs_data); end
        n_tests++; if (obs_width !== 1) begin n_fail++; $display("FAIL basic_pulse: got %0d expected 1", obs_width); end
        n_tests++; if (obs_rd !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d expected 4", obs_rd); end
    endtask

    task automatic test_len0();
        RES_READY = 1'b1;
        run_dot(0, AW'($urandom), AW'($urandom));
        n_tests++; if (obs_clr !== 1) begin n_fail++; $display("FAIL len0_clr: got %0d expected 1", obs_clr); end
        n_tests++; if (obs_rd !== 0) begin n_fail++; $display("FAIL len0_reads: got %0d expected 0", obs_rd); end
        n_tests++; if (obs_lat !== 3) begin n_fail++; $display("FAIL len0_latency: got %0d expected 3", obs_lat); end
        n_tests++; if (obs_data !== 32'd0) begin n_fail++; $display("FAIL len0_data: got %0d expected 0", obs_data); end
    endtask

    task automatic test_wrap();
        logic [AW-1:0] bb = AW'($urandom);
        logic [DW-1:0] exp_d;
        randomize_mem();
        exp_d = ref_dot(3, 8'd254, bb);
        run_dot(3, 8'd254, bb);
        n_tests++; if (obs_rd !== 3) begin n_fail++; $display("FAIL wrap_reads: got %0d expected 3", obs_rd); end
        n_tests++;
        if ({obs_a[0], obs_a[1], obs_a[2]} !== {8'd254, 8'd255, 8'd0}) begin
            n_fail++; $display("FAIL wrap_addr: got %0d %0d %0d expected 254 255 0", obs_a[0], obs_a[1], obs_a[2]);
        end
        n_tests++; if (obs_data !== exp_d) begin n_fail++; $display("FAIL wrap_data: got %h expected %h", obs_data, exp_d); end
    endtask

    task automatic test_overflow();
        mem_a[10] = 32'h0001_0000; mem_a[11] = 32'h0001_0000;
        mem_b[40] = 32'h0001_0000; mem_b[41] = 32'h0001_0000;
        run_dot(2, 8'd10, 8'd40);
        n_tests++; if (obs_data !== 32'd0) begin n_fail++; $display("FAIL overflow_data: got %h expected 0", obs_data); end
        n_tests++; if (obs_lat !== 6) begin n_fail++; $display("FAIL overflow_latency: got %0d expected 6", obs_lat); end
    endtask

    task automatic test_hold();
        logic [AW-1:0] ba = AW'($urandom);
        logic [AW-1:0] bb = AW'($urandom);
        logic [DW-1:0] exp_d;
        int n = 0;
        int unstable = 0;
        int restarted = 0;
        randomize_mem();
        exp_d = ref_dot(5, ba, bb);
        RES_READY = 1'b0;
        @(negedge CLK);
        START = 1'b1; LEN = 8'd5; BASE_A = ba; BASE_B = bb;
        @(negedge CLK);
        START = 1'b0;
        while (!RES_VALID && n < 50) begin @(negedge CLK); n++; end
        n_tests++; if (RES_VALID !== 1'b1) begin n_fail++; $display("FAIL hold_valid_seen: got %b expected 1", RES_VALID); end
        for (int k = 0; k < 5; k++) begin
            if (RES_VALID !== 1'b1 || RES_DATA !== exp_d || BUSY !== 1'b1) unstable++;
            START = (k == 1); LEN = 8'd3;
            @(negedge CLK);
        end
        START = 1'b0;
        n_tests++; if (unstable !== 0) begin n_fail++; $display("FAIL hold_stable: got %0d unstable cycles expected 0", unstable); end
        n_tests++; if (RES_DATA !== exp_d) begin n_fail++; $display("FAIL hold_data: got %h expected %h", RES_DATA, exp_d); end
        RES_READY = 1'b1; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        n_tests++; if ({RES_VALID, BUSY} !== 2'b00) begin n_fail++; $display("FAIL hold_release: got valid,busy=%b expected 00", {RES_VALID, BUSY}); end
        for (int k = 0; k < 4; k++) begin
            if (BUSY || PE_CLR || MEM_RD_EN) restarted++;
            @(negedge CLK);
        end
        n_tests++; if (restarted !== 0) begin n_fail++; $display("FAIL hold_start_ignored: got %0d busy cycles expected 0", restarted); end
        n_tests++; if (RES_DATA !== exp_d) begin n_fail++; $display("FAIL hold_retain: got %h expected %h", RES_DATA, exp_d); end
    endtask

    task automatic test_reset_mid();
        logic [DW+4*AW+4:0] outs;
        logic [AW-1:0] ba = AW'($urandom);
        logic [AW-1:0] bb = AW'($urandom);
        int spurious = 0;
        randomize_mem();
        RES_READY = 1'b1;
        @(negedge CLK);
        START = 1'b1; LEN = 8'd8; BASE_A = ba; BASE_B = bb;
        @(negedge CLK);
        START = 1'b0;
        repeat (4) @(negedge CLK);
        n_tests++; if (MEM_RD_EN !== 1'b1) begin n_fail++; $display("FAIL midrst_in_read: got %b expected 1", MEM_RD_EN); end
        #2 RST = 1'b1;
        #1;
        outs = {BUSY, MEM_RD_EN, PE_MAC, PE_CLR, RES_VALID, MEM_A_ADDR, MEM_B_ADDR, RES_DATA, PE_A[AW-1:0], PE_B[AW-1:0]};
        n_tests++; if (outs !== '0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 0", outs); end
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (RES_VALID || BUSY) spurious++;
            @(negedge CLK);
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL midrst_no_pulse: got %0d active cycles expected 0", spurious); end
        mem_a[ba] = 32'd3;
        mem_b[bb] = 32'd3;
        run_dot(1, ba, bb);
        n_tests++; if (obs_data !== 32'd9) begin n_fail++; $display("FAIL midrst_rerun_data: got %0d expected 9", obs_data); end
        n_tests++; if (obs_lat !== 5) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d expected 5", obs_lat); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 7; r++) begin
            int len = (r == 6) ? 255 : int'($urandom_range(1, 12));
            logic [AW-1:0] ba = AW'($urandom);
            logic [AW-1:0] bb = AW'($urandom);
            logic [DW-1:0] exp_d;
            int bad_addr = 0;
            randomize_mem();
            exp_d = ref_dot(len, ba, bb);
            run_dot(len, ba, bb);
            for (int i = 0; i < len && i < 256; i++) begin
                if (obs_a[i] !== ba + AW'(i) || obs_b[i] !== bb + AW'(i)) bad_addr++;
            end
            n_tests++; if (obs_lat !== len + 4) begin n_fail++; $display("FAIL rand%0d_latency: got %0d expected %0d", r, obs_lat, len + 4); end
            n_tests++; if (obs_data !== exp_d) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", r, obs_data, exp_d); end
            n_tests++; if (obs_rd !== len) begin n_fail++; $display("FAIL rand%0d_reads: got %0d expected %0d", r, obs_rd, len); end
            n_tests++; if (bad_addr !== 0) begin n_fail++; $display("FAIL rand%0d_addr: got %0d bad addresses expected 0", r, bad_addr); end
            n_tests++; if (obs_clr !== 1) begin n_fail++; $display("FAIL rand%0d_clr: got %0d expected 1", r, obs_clr); end
            n_tests++; if (obs_overlap !== 0) begin n_fail++; $display("FAIL rand%0d_clr_mac: got %0d overlaps expected 0", r, obs_overlap); end
            n_tests++; if (obs_badzero !== 0) begin n_fail++; $display("FAIL rand%0d_pe_zero: got %0d unmasked expected 0", r, obs_badzero); end
            n_tests++; if (obs_width !== 1) begin n_fail++; $display("FAIL rand%0d_pulse: got %0d expected 1", r, obs_width); end
            n_tests++; if (obs_busy_after !== 1'b0) begin n_fail++; $display("FAIL rand%0d_idle: got busy %b expected 0", r, obs_busy_after); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_wrap();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
